// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the DAC frame scheduler.
//   dac_state_e   frame sequencer states
//   DAC_WORD_W    width of the main and compensation DAC words
//   *_DEF         default timing parameters (adc_clk cycles)
//   rotl1()       one-bit rotate-left of a DAC word
package dac_pkg;

  localparam int DAC_WORD_W      = 16;
  localparam int HALF_PERIOD_DEF = 8;
  localparam int LDAC_WIDTH_DEF  = 2;
  localparam int CS_HOLD_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCK_LO,
    ST_SCK_HI,
    ST_CS_END,
    ST_LDAC,
    ST_GAP
  } dac_state_e;

  function automatic logic [DAC_WORD_W-1:0] rotl1(input logic [DAC_WORD_W-1:0] w);
    return {w[DAC_WORD_W-2:0], w[DAC_WORD_W-1]};
  endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// dac_rr_arbiter: two-input round-robin grant.
//   clk, reset_n  clock, synchronous active-low reset
//   en            grant allowed this cycle (scheduler idle)
//   valid[1:0]    request levels
//   ack[1:0]      one-hot grant, combinational, only while en
//   grant_id      index of the granted requester (meaningful with |ack)
// On a tie the requester not granted last time wins; a lone requester
// always wins. last_grant resets to 1 so requester 0 wins the first tie.
module dac_rr_arbiter
  import dac_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] ack,
  output logic       grant_id
);

  logic last_q, last_d;

  always_comb begin
    ack      = 2'b00;
    grant_id = 1'b0;
    last_d   = last_q;
    if (en && (|valid)) begin
      grant_id = (valid[0] && valid[1]) ? ~last_q : valid[1];
      ack      = grant_id ? 2'b10 : 2'b01;
      last_d   = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler: shares the bias/compensation DAC pair between the
// host command path (req0) and the sweep sequencer (req1). One frame shifts
// a 16-bit main and a 16-bit compensation word out together, MSB-first,
// framed by cs_DAC, clocked by clk_2_DAC and committed by an ldac_DAC pulse.
//   adc_clk, reset_n           clock, synchronous active-low reset
//   reqN_valid/main/comp/ack   requester handshakes (ack is a 1-cycle pulse
//                              in the cycle the words are captured)
//   done, done_id              1-cycle completion pulse with frame owner
//   busy                       frame in flight
//   cs_DAC, clk_2_DAC, din_DAC, din_DAC_compensation, ldac_DAC   DAC pins
// Optional: define DAC_SHADOW_EN to add last_main/last_comp/last_owner,
// which hold the most recently committed frame.
module dac_frame_scheduler
  import dac_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int LDAC_WIDTH  = LDAC_WIDTH_DEF,
  parameter int CS_HOLD     = CS_HOLD_DEF
) (
  input  logic                  adc_clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [DAC_WORD_W-1:0] req0_main,
  input  logic [DAC_WORD_W-1:0] req0_comp,
  output logic                  req0_ack,
  input  logic                  req1_valid,
  input  logic [DAC_WORD_W-1:0] req1_main,
  input  logic [DAC_WORD_W-1:0] req1_comp,
  output logic                  req1_ack,
  output logic                  done,
  output logic                  done_id,
  output logic                  busy,
  output logic                  cs_DAC,
  output logic                  clk_2_DAC,
  output logic                  din_DAC,
  output logic                  din_DAC_compensation,
  output logic                  ldac_DAC
`ifdef DAC_SHADOW_EN
  ,
  output logic [DAC_WORD_W-1:0] last_main,
  output logic [DAC_WORD_W-1:0] last_comp,
  output logic                  last_owner
`endif
);

  localparam logic [7:0] HP_M1 = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] CS_M1 = 8'(CS_HOLD - 1);
  localparam logic [7:0] LW_M1 = 8'(LDAC_WIDTH - 1);

  dac_state_e            state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [DAC_WORD_W-1:0] main_q, main_d, comp_q, comp_d;
  logic                  owner_q, owner_d;
  logic                  hold2_q, hold2_d;   // second half of CS_END (cs already high)
  logic                  cs_q, cs_d, sck_q, sck_d, ldac_q, ldac_d;
  logic                  done_q, done_d, done_id_q, done_id_d, busy_q, busy_d;
`ifdef DAC_SHADOW_EN
  logic [DAC_WORD_W-1:0] last_main_q, last_main_d, last_comp_q, last_comp_d;
  logic                  last_owner_q, last_owner_d;
`endif

  logic [1:0] ack;
  logic       grant_id;

  // Gate on reset_n so no ack is shown in a cycle whose edge resets the block.
  dac_rr_arbiter u_arb (
    .clk      (adc_clk),
    .reset_n  (reset_n),
    .en       ((state_q == ST_IDLE) && reset_n),
    .valid    ({req1_valid, req0_valid}),
    .ack      (ack),
    .grant_id (grant_id)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    main_d    = main_q;
    comp_d    = comp_q;
    owner_d   = owner_q;
    hold2_d   = hold2_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    ldac_d    = ldac_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    busy_d    = busy_q;
`ifdef DAC_SHADOW_EN
    last_main_d  = last_main_q;
    last_comp_d  = last_comp_q;
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|ack) begin
          // The shift registers drive the data pins directly from their MSB,
          // so bit 15 is already presented during LOAD.
          main_d  = grant_id ? req1_main : req0_main;
          comp_d  = grant_id ? req1_comp : req0_comp;
          owner_d = grant_id;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cs_d    = 1'b0;
        bit_d   = 4'd15;
        div_d   = HP_M1;
        state_d = ST_SCK_LO;
      end
      ST_SCK_LO: begin
        if (div_q == 8'd0) begin
          sck_d   = 1'b1;
          div_d   = HP_M1;
          state_d = ST_SCK_HI;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_SCK_HI: begin
        if (div_q == 8'd0) begin
          sck_d = 1'b0;
          if (bit_q == 4'd0) begin
            div_d   = CS_M1;
            hold2_d = 1'b0;
            state_d = ST_CS_END;
          end else begin
            // Rotate rather than shift: after 15 rotations one more rotate
            // restores the original word for the shadow registers.
            main_d  = rotl1(main_q);
            comp_d  = rotl1(comp_q);
            bit_d   = bit_q - 4'd1;
            div_d   = HP_M1;
            state_d = ST_SCK_LO;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_CS_END: begin
        if (div_q == 8'd0) begin
          div_d = CS_M1;
          if (!hold2_q) begin
            cs_d    = 1'b1;
            hold2_d = 1'b1;
          end else begin
            ldac_d  = 1'b0;
            div_d   = LW_M1;
            state_d = ST_LDAC;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_LDAC: begin
        if (div_q == 8'd0) begin
          ldac_d    = 1'b1;
          done_d    = 1'b1;
          done_id_d = owner_q;
`ifdef DAC_SHADOW_EN
          last_main_d  = rotl1(main_q);
          last_comp_d  = rotl1(comp_q);
          last_owner_d = owner_q;
`endif
          state_d = ST_GAP;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_GAP: begin
        busy_d  = 1'b0;
        main_d  = '0;
        comp_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      main_q    <= '0;
      comp_q    <= '0;
      owner_q   <= 1'b0;
      hold2_q   <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      ldac_q    <= 1'b1;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DAC_SHADOW_EN
      last_main_q  <= '0;
      last_comp_q  <= '0;
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      main_q    <= main_d;
      comp_q    <= comp_d;
      owner_q   <= owner_d;
      hold2_q   <= hold2_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      ldac_q    <= ldac_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
`ifdef DAC_SHADOW_EN
      last_main_q  <= last_main_d;
      last_comp_q  <= last_comp_d;
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign req0_ack             = ack[0];
  assign req1_ack             = ack[1];
  assign done                 = done_q;
  assign done_id              = done_id_q;
  assign busy                 = busy_q;
  assign cs_DAC               = cs_q;
  assign clk_2_DAC            = sck_q;
  assign din_DAC              = main_q[DAC_WORD_W-1];
  assign din_DAC_compensation = comp_q[DAC_WORD_W-1];
  assign ldac_DAC             = ldac_q;
`ifdef DAC_SHADOW_EN
  assign last_main  = last_main_q;
  assign last_comp  = last_comp_q;
  assign last_owner = last_owner_q;
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler: two scheduler instances (default timing, and
// HALF_PERIOD=LDAC_WIDTH=CS_HOLD=1) checked every cycle against a
// time-based reference model: frame windows are derived from the ack cycle
// with plain arithmetic, serial words are reassembled from clk_2_DAC rises.
module tb_dac_frame_scheduler;

  logic        gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic        reset_n = 1'b0;
  int unsigned cyc_cnt = 0;
  always @(posedge gclk) cyc_cnt <= cyc_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_cnt);
    end
  endtask

  // Per-instance stimulus and observation; [inst][requester]
  logic [1:0]  rv [2];
  logic [15:0] rm [2][2];
  logic [15:0] rc [2][2];
  bit          ackd [2][2];
  int          rises [2];
  logic [1:0]  a0, a1, dn, dnid, bsy, cs, sck, din, dinc, ldac;
`ifdef DAC_SHADOW_EN
  logic [15:0] lm [2];
  logic [15:0] lc [2];
  logic [1:0]  lo;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int HP = (gi == 0) ? 8 : 1;
    localparam int LW = (gi == 0) ? 2 : 1;
    localparam int CS = (gi == 0) ? 8 : 1;
    localparam int SP = 3 + 32*HP + 2*CS + LW;   // ack-to-ack spacing

    dac_frame_scheduler #(.HALF_PERIOD(HP), .LDAC_WIDTH(LW), .CS_HOLD(CS)) u_dut (
      .adc_clk              (gclk),
      .reset_n              (reset_n),
      .req0_valid           (rv[gi][0]),
      .req0_main            (rm[gi][0]),
      .req0_comp            (rc[gi][0]),
      .req0_ack             (a0[gi]),
      .req1_valid           (rv[gi][1]),
      .req1_main            (rm[gi][1]),
      .req1_comp            (rc[gi][1]),
      .req1_ack             (a1[gi]),
      .done                 (dn[gi]),
      .done_id              (dnid[gi]),
      .busy                 (bsy[gi]),
      .cs_DAC               (cs[gi]),
      .clk_2_DAC            (sck[gi]),
      .din_DAC              (din[gi]),
      .din_DAC_compensation (dinc[gi]),
      .ldac_DAC             (ldac[gi])
`ifdef DAC_SHADOW_EN
      ,
      .last_main            (lm[gi]),
      .last_comp            (lc[gi]),
      .last_owner           (lo[gi])
`endif
    );

    bit          armed = 0, act = 0, last = 1, eo = 0;
    int unsigned free_at = 0, ack_c = 0;
    logic [15:0] em = '0, ec = '0, cm = '0, cc = '0;
    logic        sck_prev = 1'b0;
`ifdef DAC_SHADOW_EN
    logic [15:0] sm = '0, sc = '0;
    bit          so = 0;
`endif

    always @(negedge gclk) begin
      int unsigned c, k;
      logic [2:0]  ep;
      logic [1:0]  ea;
      bit          gw;
      c = cyc_cnt;
      if (armed) begin
        // Expected pins from the position inside the frame
        k  = (act && c > ack_c) ? c - ack_c : 0;
        ep = 3'b101;                                   // {cs, sck, ldac}
        if (k >= 2 && k < 2 + 32*HP) begin
          ep[2] = 1'b0;
          ep[1] = (((k - 2) / HP) % 2) == 1;
        end else if (k >= 2 + 32*HP && k < 2 + 32*HP + CS) begin
          ep = 3'b001;
        end else if (k >= 2 + 32*HP + 2*CS && k < SP - 1) begin
          ep = 3'b100;
        end
        chk($sformatf("pins%0d", gi), 64'({cs[gi], sck[gi], ldac[gi]}), 64'(ep));
        chk($sformatf("busy%0d", gi), 64'(bsy[gi]), 64'(k >= 1));
        if (k == 0) chk($sformatf("din_idle%0d", gi), 64'({din[gi], dinc[gi]}), 64'(0));

        if (act && sck[gi] === 1'b1 && sck_prev === 1'b0) begin
          cm = {cm[14:0], din[gi]};
          cc = {cc[14:0], dinc[gi]};
          rises[gi]++;
        end

        if (act && c == ack_c + SP - 1) begin
          chk($sformatf("done%0d", gi), 64'({dn[gi], dnid[gi]}), 64'({1'b1, eo}));
          chk($sformatf("main_word%0d", gi), 64'(cm), 64'(em));
          chk($sformatf("comp_word%0d", gi), 64'(cc), 64'(ec));
          chk($sformatf("rises%0d", gi), 64'(rises[gi]), 64'(16));
          act = 0;
`ifdef DAC_SHADOW_EN
          sm = em; sc = ec; so = eo;
`endif
        end else begin
          chk($sformatf("done%0d", gi), 64'(dn[gi]), 64'(0));
        end

        ea = 2'b00;
        gw = 0;
        if (reset_n && c >= free_at && (rv[gi][0] || rv[gi][1])) begin
          gw = (rv[gi][0] && rv[gi][1]) ? !last : rv[gi][1];
          ea = gw ? 2'b10 : 2'b01;
        end
        chk($sformatf("ack%0d", gi), 64'({a1[gi], a0[gi]}), 64'(ea));
        if (ea != 2'b00) begin
          last    = gw;
          act     = 1;
          ack_c   = c;
          free_at = c + SP;
          em      = rm[gi][gw];
          ec      = rc[gi][gw];
          eo      = gw;
          cm      = '0;
          cc      = '0;
          rises[gi] = 0;
          ackd[gi][gw] = 1;
        end
`ifdef DAC_SHADOW_EN
        chk($sformatf("shadow%0d", gi), 64'({lo[gi], lm[gi], lc[gi]}), 64'({so, sm, sc}));
`endif
      end
      sck_prev = sck[gi];
      if (!reset_n) begin
        armed   = 1;
        act     = 0;
        last    = 1;
        free_at = c + 1;
`ifdef DAC_SHADOW_EN
        sm = '0; sc = '0; so = 0;
`endif
      end
    end
  end

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_ackd();
    for (int i = 0; i < 2; i++) begin
      ackd[i][0] = 0;
      ackd[i][1] = 0;
    end
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    step_n(2);
    reset_n = 1'b1;
    clr_ackd();
  endtask

  task automatic wait_any(input int i, output int who, output int unsigned t);
    bit found = 0;
    who = -1;
    t   = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      step();
      if (ackd[i][0] || ackd[i][1]) begin
        found = 1;
        who   = ackd[i][1] ? 1 : 0;
        t     = cyc_cnt;
        ackd[i][0] = 0;
        ackd[i][1] = 0;
      end
    end
    chk("ack_wait", 64'(found), 64'(1));
  endtask

  task automatic wait_ack(input int i, input int r);
    int          who;
    int unsigned t;
    wait_any(i, who, t);
    chk("ack_owner", 64'(who), 64'(r));
    rv[i][r] = 1'b0;
  endtask

  initial begin
    int          who;
    int unsigned t, tp;
    bit          hit;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 2'b00;
      for (int r = 0; r < 2; r++) begin
        rm[i][r] = '0;
        rc[i][r] = '0;
      end
    end
    clr_ackd();
    step_n(3);
    reset_n = 1'b1;

    // Single frames: A5C3/0F0F on default timing, FFFF/0000 on fastest timing
    rm[0][0] = 16'hA5C3; rc[0][0] = 16'h0F0F; rv[0][0] = 1'b1;
    rm[1][0] = 16'hFFFF; rc[1][0] = 16'h0000; rv[1][0] = 1'b1;
    wait_ack(0, 0);
    wait_ack(1, 0);
    step_n(300);

    // Both requesters held: grants alternate, acks 277 cycles apart
    reset_pulse();
    rm[0][0] = 16'($urandom); rc[0][0] = 16'($urandom);
    rm[0][1] = 16'($urandom); rc[0][1] = 16'($urandom);
    rv[0] = 2'b11;
    tp = 0;
    for (int n = 0; n < 4; n++) begin
      wait_any(0, who, t);
      chk("rr_order", 64'(who), 64'(n % 2));
      if (n > 0) chk("ack_spacing", 64'(t - tp), 64'(277));
      tp = t;
      if (who >= 0) begin
        rm[0][who] = 16'($urandom);
        rc[0][who] = 16'($urandom);
      end
    end
    rv[0] = 2'b00;
    step_n(300);
    clr_ackd();

    // Lone req1 twice back-to-back
    rm[0][1] = 16'($urandom); rc[0][1] = 16'($urandom);
    rv[0][1] = 1'b1;
    wait_any(0, who, tp);
    chk("lone_req1_a", 64'(who), 64'(1));
    rm[0][1] = 16'($urandom); rc[0][1] = 16'($urandom);
    wait_any(0, who, t);
    chk("lone_req1_b", 64'(who), 64'(1));
    chk("lone_spacing", 64'(t - tp), 64'(277));
    rv[0][1] = 1'b0;
    step_n(300);
    clr_ackd();

    // Reset at the 7th serial-clock rise, then a fresh frame
    rm[0][0] = 16'($urandom); rc[0][0] = 16'($urandom);
    rv[0][0] = 1'b1;
    wait_ack(0, 0);
    hit = 0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      if (rises[0] >= 7) hit = 1;
      else step();
    end
    chk("rise7_wait", 64'(hit), 64'(1));
    reset_n = 1'b0;
    step();
    chk("rst_pins", 64'({cs[0], ldac[0], bsy[0], dn[0], sck[0]}), 64'(5'b11000));
    reset_n = 1'b1;
    clr_ackd();
    rm[0][0] = 16'($urandom); rc[0][0] = 16'($urandom);
    rv[0][0] = 1'b1;
    wait_ack(0, 0);
    step_n(300);

    // Random traffic: valids toggling/dropping, data changing every cycle
    for (int n = 0; n < 5000; n++) begin
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          if (rv[i][r] && ackd[i][r]) rv[i][r] = ($urandom_range(2) == 0);
          else if (rv[i][r])          rv[i][r] = ($urandom_range(40) != 0);
          else                        rv[i][r] = ($urandom_range(6) == 0);
          ackd[i][r] = 0;
          rm[i][r] = 16'($urandom);
          rc[i][r] = 16'($urandom);
        end
      end
      reset_n = ($urandom_range(1999) != 0);
      step();
    end
    reset_n = 1'b1;
    rv[0] = 2'b00;
    rv[1] = 2'b00;
    step_n(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
